clk_period_meter: RTL
=====================

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the period and high-time counters and outputs.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, minimum 2: number of flops in the input synchronizer.
REQ-003 SHALL have port clk_in, input, 1 bit: single reference clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous to clk_in and active-high.
REQ-005 SHALL have port sig_in, input, 1 bit: asynchronous clock-like signal under measurement, e.g. a divided clock.
REQ-006 SHALL have port en, input, 1 bit: measurement enable.
REQ-007 SHALL have port exp_period, input, CNT_W bits: expected period in clk_in cycles.
REQ-008 SHALL have port tol, input, CNT_W bits: allowed absolute period deviation in clk_in cycles.
REQ-009 SHALL have port period, output, CNT_W bits: last measured period in clk_in cycles.
REQ-010 SHALL have port high_time, output, CNT_W bits: clk_in cycles with synchronized sig_in high during that period.
REQ-011 SHALL have port meas_valid, output, 1 bit: one-cycle pulse when period and high_time update.
REQ-012 SHALL have port period_err, output, 1 bit: registered with meas_valid; high when |period - exp_period| > tol.
REQ-013 SHALL have port timeout, output, 1 bit: one-cycle pulse on counter saturation.

Function
REQ-014 SHALL pass sig_in through SYNC_STAGES flops; s = last stage; s_d = s delayed one cycle; rise = s & ~s_d.
REQ-015 SHALL implement the states IDLE, WAIT_RISE and MEASURE.
REQ-016 SHALL go IDLE->WAIT_RISE when en=1; WAIT_RISE->MEASURE on rise; MEASURE->WAIT_RISE on saturation; any state->IDLE when en=0.
REQ-017 SHALL, in any cycle with rise and state entering or in MEASURE, load pcnt=1 and hcnt=1.
REQ-018 SHALL, otherwise in MEASURE, increment pcnt each cycle and increment hcnt each cycle that s=1.
REQ-019 SHALL, on rise in MEASURE, register period=pcnt and high_time=hcnt, and pulse meas_valid in the following cycle.
REQ-020 SHALL give a period equal to the number of clk_in cycles between consecutive detected rises; a synchronous 50% divide-by-4 gives period=4 and high_time=2.
REQ-021 SHALL produce no meas_valid on the first rise after entering MEASURE; the first report needs two rises.
REQ-022 SHALL compute period_err from the new period value, using CNT_W+1-bit magnitude arithmetic with no wrap; tol=0 flags any mismatch.
REQ-023 SHALL treat pcnt=2^CNT_W-1 with no rise as saturation: pulse timeout next cycle, clear pcnt and hcnt, enter WAIT_RISE, leave period and high_time unchanged.
REQ-024 SHALL, on rise in the same cycle as pcnt at max, report the measurement with no timeout.
REQ-025 SHALL, on en falling in the same cycle as rise, give priority to en: no meas_valid, go to IDLE.
REQ-026 SHALL hold period, high_time and period_err in IDLE at their last values; meas_valid and timeout SHALL be 0.
REQ-027 SHALL sample exp_period and tol only in the report cycle.
REQ-028 SHALL have latency from sig_in rising (meeting setup) to meas_valid of SYNC_STAGES+1 clk_in cycles.

Reset
REQ-029 SHALL, with rst=1 at a clk_in edge, clear the synchronizer flops, s_d, pcnt and hcnt, set state IDLE, and clear period, high_time, meas_valid, period_err and timeout to 0.
REQ-030 SHALL, on rst mid-measurement, discard the partial count; the next report needs two fresh rises.
REQ-031 SHALL give rst priority over en and over rise.

Verification
REQ-032 Bench SHALL drive en=1 with sig_in a synchronous 50% divide-by-4 for 5 periods -> period=4, high_time=2, meas_valid every 4 cycles starting after the 2nd rise.
REQ-033 Bench SHALL drive a divide-by-5 with exp_period=5, tol=0, then switch to divide-by-6 -> period_err=0 for period 5, and period_err=1 at the first period=6 report.
REQ-034 Bench SHALL set CNT_W=4 and hold sig_in low after one rise -> timeout pulse once pcnt reaches 15, then WAIT_RISE; period keeps its prior value.
REQ-035 Bench SHALL drop en in the cycle of a rise -> no meas_valid; re-enable -> the first report after two further rises.
REQ-036 Bench SHALL assert rst for 1 cycle mid-period -> all outputs 0 next cycle; reports resume only after 2 rises with en=1.
REQ-037 Bench SHALL align the rise with pcnt at max (CNT_W=4, 15-cycle period) -> meas_valid with period=15 and no timeout.

Source files
------------

// File: rtl/clk_period_meter.sv
// Measures the period and high time of an asynchronous clock-like input in reference-clock cycles.
// Latency: sig_in rising edge to meas_valid is SYNC_STAGES+1 clk_in cycles.
// No backpressure: results are one-cycle pulses with held data; counter saturation raises a timeout pulse.
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             en,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [CNT_W-1:0] tol,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             period_err,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic [CNT_W-1:0]       pcnt;
    logic [CNT_W-1:0]       hcnt;
    logic                   pcnt_max;
    logic [CNT_W:0]         p_ext;
    logic [CNT_W:0]         e_ext;
    logic [CNT_W:0]         abs_diff;
    logic                   err_next;

    // Bring the asynchronous input into the clk_in domain.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~s_d;
    assign pcnt_max = (pcnt == {CNT_W{1'b1}});

    // Deviation check on one extra bit so neither subtraction can wrap.
    always_comb begin
        p_ext    = {1'b0, pcnt};
        e_ext    = {1'b0, exp_period};
        abs_diff = (p_ext >= e_ext) ? (p_ext - e_ext) : (e_ext - p_ext);
        err_next = (abs_diff > {1'b0, tol});
    end

    // Measurement FSM: counters, result registers and status pulses.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            pcnt       <= '0;
            hcnt       <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            period_err <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (!en) begin
                // Disable wins over a coincident rise; partial counts are dropped.
                state <= IDLE;
                pcnt  <= '0;
                hcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT_RISE;
                        pcnt  <= '0;
                        hcnt  <= '0;
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            // First edge only opens the window; nothing to report yet.
                            state <= MEASURE;
                            pcnt  <= CNT_W'(1);
                            hcnt  <= CNT_W'(1);
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            // A rise at full count is still a valid measurement.
                            period     <= pcnt;
                            high_time  <= hcnt;
                            period_err <= err_next;
                            meas_valid <= 1'b1;
                            pcnt       <= CNT_W'(1);
                            hcnt       <= CNT_W'(1);
                        end else if (pcnt_max) begin
                            // Input stalled: give up and resynchronise on the next rise.
                            timeout <= 1'b1;
                            pcnt    <= '0;
                            hcnt    <= '0;
                            state   <= WAIT_RISE;
                        end else begin
                            pcnt <= pcnt + CNT_W'(1);
                            if (s) begin
                                hcnt <= hcnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        pcnt  <= '0;
                        hcnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
